// File: rtl/demux_rr_n_if.sv
// Bus bundle for demux_rr_n: one input word stream in, NCH registered lanes out.
// err_out exists only when DEMUX_ERR_EN is defined.
interface demux_rr_n_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 2
);
    localparam int unsigned SELW = (NCH > 2) ? $clog2(NCH) : 1;

    logic [WIDTH-1:0]     data_in;
    logic                 valid_in;
    logic [SELW-1:0]      sel_in;
    logic                 sync_in;
    logic [NCH*WIDTH-1:0] data_out;
    logic [NCH-1:0]       valid_out;
    logic [SELW-1:0]      ptr_out;
`ifdef DEMUX_ERR_EN
    logic                 err_out;

    modport master (
        output data_in, valid_in, sel_in, sync_in,
        input  data_out, valid_out, ptr_out, err_out
    );
    modport slave (
        input  data_in, valid_in, sel_in, sync_in,
        output data_out, valid_out, ptr_out, err_out
    );
`else
    modport master (
        output data_in, valid_in, sel_in, sync_in,
        input  data_out, valid_out, ptr_out
    );
    modport slave (
        input  data_in, valid_in, sel_in, sync_in,
        output data_out, valid_out, ptr_out
    );
`endif
endinterface

// File: rtl/demux_rr_n.sv
// 1:NCH word demultiplexer (round-robin or explicit select) with per-lane registers.
// Optional macro DEMUX_ERR_EN adds err_out for out-of-range select / sync misalignment.
module demux_rr_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 2,
    parameter int unsigned MODE  = 0
) (
    input  logic            clk_2f,
    input  logic            reset,
    demux_rr_n_if.slave     bus
);
    localparam int unsigned SELW = (NCH > 2) ? $clog2(NCH) : 1;

    logic [SELW-1:0]      ptr_q, ptr_d;
    logic [NCH*WIDTH-1:0] data_q, data_d;
    logic [NCH-1:0]       valid_q, valid_d;
    logic [SELW-1:0]      lane_c;
    logic                 in_range_c;
    logic                 wr_c;
`ifdef DEMUX_ERR_EN
    logic                 err_q, err_d;
`endif

    // Select codes >= NCH only exist when NCH is not a power of two.
    if (NCH == (32'(1) << SELW)) begin : g_pow2
        assign in_range_c = 1'b1;
    end else begin : g_npow2
        assign in_range_c = (bus.sel_in <= SELW'(NCH - 1));
    end

    // Target lane; sync forces lane 0 ahead of the pointer.
    always_comb begin
        lane_c = '0;
        wr_c   = 1'b0;
        if (MODE == 0) begin
            lane_c = bus.sync_in ? '0 : ptr_q;
            wr_c   = bus.valid_in;
        end else begin
            lane_c = bus.sel_in;
            wr_c   = bus.valid_in && in_range_c;
        end
    end

    // Next state for lane registers, strobes and pointer.
    always_comb begin
        data_d  = data_q;
        valid_d = '0;
        ptr_d   = ptr_q;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (wr_c && (lane_c == SELW'(k))) begin
                data_d[k*WIDTH +: WIDTH] = bus.data_in;
                valid_d[k]               = 1'b1;
            end
        end
        if (MODE == 0) begin
            if (bus.valid_in) begin
                ptr_d = (lane_c == SELW'(NCH - 1)) ? '0 : lane_c + SELW'(1);
            end else if (bus.sync_in) begin
                ptr_d = '0;
            end
        end else begin
            ptr_d = '0;
        end
    end

`ifdef DEMUX_ERR_EN
    always_comb begin
        err_d = 1'b0;
        if (bus.valid_in) begin
            if (MODE == 0) begin
                err_d = bus.sync_in && (ptr_q != '0);
            end else begin
                err_d = !in_range_c;
            end
        end
    end
`endif

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
`ifdef DEMUX_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
`ifdef DEMUX_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.ptr_out   = ptr_q;
`ifdef DEMUX_ERR_EN
    assign bus.err_out   = err_q;
`endif

endmodule

// File: tb/tb_demux_rr_n.sv
// Directed scoreboard bench: three demux_rr_n instances (NCH=2/3 round-robin, NCH=3 select)
// share one stimulus stream and are compared against a behavioural lane model.
module tb_demux_rr_n;

    typedef struct {
        logic [1:0]      ptr;
        logic [2:0][7:0] lanes;
        logic [2:0]      vout;
        logic            err;
    } mst_t;

    typedef struct {
        mst_t a;
        mst_t b;
        mst_t c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       v;
    logic [1:0] sel;
    logic       sy;

    mst_t ma, mb, mc;
    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    demux_rr_n_if #(.WIDTH(8), .NCH(2)) if_a ();
    demux_rr_n_if #(.WIDTH(8), .NCH(3)) if_b ();
    demux_rr_n_if #(.WIDTH(8), .NCH(3)) if_c ();

    assign if_a.data_in  = d;
    assign if_a.valid_in = v;
    assign if_a.sel_in   = sel[0];
    assign if_a.sync_in  = sy;
    assign if_b.data_in  = d;
    assign if_b.valid_in = v;
    assign if_b.sel_in   = sel;
    assign if_b.sync_in  = sy;
    assign if_c.data_in  = d;
    assign if_c.valid_in = v;
    assign if_c.sel_in   = sel;
    assign if_c.sync_in  = sy;

    demux_rr_n #(.WIDTH(8), .NCH(2), .MODE(0)) u_a (.clk_2f(clk), .reset(rst), .bus(if_a));
    demux_rr_n #(.WIDTH(8), .NCH(3), .MODE(0)) u_b (.clk_2f(clk), .reset(rst), .bus(if_b));
    demux_rr_n #(.WIDTH(8), .NCH(3), .MODE(1)) u_c (.clk_2f(clk), .reset(rst), .bus(if_c));

    function automatic mst_t mzero();
        mst_t z;
        z.ptr   = '0;
        z.lanes = '0;
        z.vout  = '0;
        z.err   = 1'b0;
        return z;
    endfunction

    // Behavioural lane model: state after one clock edge.
    function automatic mst_t mdl(input mst_t s, input int nch, input int mode, input logic vi,
                                 input logic [7:0] di, input logic [1:0] si, input logic syi);
        mst_t n;
        int   lane;
        n      = s;
        n.vout = '0;
        n.err  = 1'b0;
        if (mode == 0) begin
            if (vi) begin
                lane          = syi ? 0 : int'(s.ptr);
                n.lanes[lane] = di;
                n.vout[lane]  = 1'b1;
                n.err         = syi && (s.ptr != 2'd0);
                n.ptr         = (lane == nch - 1) ? 2'd0 : 2'(lane + 1);
            end else if (syi) begin
                n.ptr = 2'd0;
            end
        end else begin
            n.ptr = 2'd0;
            if (vi) begin
                if (int'(si) < nch) begin
                    n.lanes[int'(si)] = di;
                    n.vout[int'(si)]  = 1'b1;
                end else begin
                    n.err = 1'b1;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cmp_all(input exp_t e);
        chk("a.valid_out", 32'(if_a.valid_out), 32'(e.a.vout[1:0]));
        chk("a.data_out",  32'(if_a.data_out),  32'({e.a.lanes[1], e.a.lanes[0]}));
        chk("a.ptr_out",   32'(if_a.ptr_out),   32'(e.a.ptr));
        chk("b.valid_out", 32'(if_b.valid_out), 32'(e.b.vout));
        chk("b.data_out",  32'(if_b.data_out),  32'(e.b.lanes));
        chk("b.ptr_out",   32'(if_b.ptr_out),   32'(e.b.ptr));
        chk("c.valid_out", 32'(if_c.valid_out), 32'(e.c.vout));
        chk("c.data_out",  32'(if_c.data_out),  32'(e.c.lanes));
        chk("c.ptr_out",   32'(if_c.ptr_out),   32'(e.c.ptr));
`ifdef DEMUX_ERR_EN
        chk("a.err_out", 32'(if_a.err_out), 32'(e.a.err));
        chk("b.err_out", 32'(if_b.err_out), 32'(e.b.err));
        chk("c.err_out", 32'(if_c.err_out), 32'(e.c.err));
`endif
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.a = ma;
        e.b = mb;
        e.c = mc;
        return e;
    endfunction

    // Drive one cycle, push the expected post-edge state, then pop and compare after the edge.
    task automatic step(input logic vi, input logic [7:0] di, input logic [1:0] si, input logic syi);
        v   = vi;
        d   = di;
        sel = si;
        sy  = syi;
        ma  = mdl(ma, 2, 0, vi, di, {1'b0, si[0]}, syi);
        mb  = mdl(mb, 3, 0, vi, di, si, syi);
        mc  = mdl(mc, 3, 1, vi, di, si, syi);
        sb_q.push_back(snap());
        @(posedge clk);
        #1;
        cmp_all(sb_q.pop_front());
    endtask

    task automatic reset_models();
        ma = mzero();
        mb = mzero();
        mc = mzero();
    endtask

    initial begin
        rst = 1'b1;
        v   = 1'b0;
        d   = 8'h00;
        sel = 2'd0;
        sy  = 1'b0;
        reset_models();
        repeat (2) @(posedge clk);
        #1;
        cmp_all(snap());
        rst = 1'b0;

        // Back-to-back round-robin words.
        step(1'b1, 8'h24, 2'd0, 1'b0);
        step(1'b1, 8'h81, 2'd0, 1'b0);
        step(1'b1, 8'h09, 2'd0, 1'b0);
        step(1'b1, 8'h63, 2'd0, 1'b0);

        // Gaps: invalid words never appear and the pointer holds.
        step(1'b1, 8'h0D, 2'd0, 1'b0);
        step(1'b0, 8'h8D, 2'd0, 1'b0);
        step(1'b0, 8'h65, 2'd0, 1'b0);
        step(1'b1, 8'h12, 2'd0, 1'b0);

        // Non-power-of-two wrap, then sync while misaligned.
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 2'd1, 1'b0);
        step(1'b1, 8'h06, 2'd0, 1'b1);
        step(1'b1, 8'h07, 2'd0, 1'b1);
        step(1'b0, 8'h00, 2'd0, 1'b1);

        // Explicit select, including the out-of-range code.
        step(1'b1, 8'hAA, 2'd2, 1'b0);
        step(1'b1, 8'hBB, 2'd3, 1'b0);
        step(1'b1, 8'hCC, 2'd1, 1'b0);
        step(1'b1, 8'hDD, 2'd0, 1'b1);
        step(1'b0, 8'hEE, 2'd3, 1'b0);

        // Reset mid-cycle: outputs clear without waiting for an edge; word in flight is dropped.
        step(1'b1, 8'h31, 2'd0, 1'b0);
        step(1'b1, 8'h32, 2'd1, 1'b0);
        step(1'b1, 8'h33, 2'd2, 1'b0);
        #2;
        v   = 1'b1;
        d   = 8'hEE;
        rst = 1'b1;
        reset_models();
        #1;
        cmp_all(snap());
        @(posedge clk);
        #1;
        cmp_all(snap());
        rst = 1'b0;
        step(1'b1, 8'h5A, 2'd0, 1'b0);

        // Undriven data while idle must not reach any output.
        for (int i = 0; i < 4; i++) step(1'b0, 8'hxx, 2'd0, 1'b0);
        step(1'b1, 8'hA5, 2'd2, 1'b0);
        step(1'b1, 8'h3C, 2'd1, 1'b0);
        step(1'b0, 8'h00, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
